pi1_rr_buf: RTL and testbench

PI1_RR_BUF -- requirements
Module: pi1_rr_buf

---
 rtl/pi1_rr_buf.sv | 195 +++++++++++++++++++
 tb/tb_pi1_rr_buf.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi1_rr_buf.sv
// Round-robin request buffer: one request slot per master, a single output
// register toward the slave, and one outstanding read whose data returns on a later s_rdy_i.
module pi1_rr_buf #(
   parameter  int unsigned MASTERCOUNT = 2,
   parameter  int unsigned ARCHBITSZ   = 16,
   localparam int unsigned ADDRBITSZ   = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [2*MASTERCOUNT-1:0]            m_op_i_flat,
   input  logic [ADDRBITSZ*MASTERCOUNT-1:0]    m_addr_i_flat,
   input  logic [ARCHBITSZ*MASTERCOUNT-1:0]    m_data_i_flat,
   input  logic [(ARCHBITSZ/8)*MASTERCOUNT-1:0] m_sel_i_flat,
   output logic [ARCHBITSZ*MASTERCOUNT-1:0]    m_data_o_flat,
   output logic [MASTERCOUNT-1:0]              m_rdy_o_flat,
   output logic [1:0]                          s_op_o,
   output logic [ADDRBITSZ-1:0]                s_addr_o,
   output logic [ARCHBITSZ-1:0]                s_data_o,
   output logic [ARCHBITSZ/8-1:0]              s_sel_o,
   input  logic [ARCHBITSZ-1:0]                s_data_i,
   input  logic                                s_rdy_i
);

   localparam int unsigned SELW = ARCHBITSZ/8;
   localparam int unsigned PW   = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1;

   typedef enum logic [1:0] {
      OP_NOOP = 2'b00,
      OP_WR   = 2'b01,
      OP_RD   = 2'b10,
      OP_RW   = 2'b11
   } op_e;

   // Slot state: sv = occupied, si = already moved to the output register
   logic [MASTERCOUNT-1:0] sv_q, sv_d, si_q, si_d, rw_q, rw_d;
   op_e                    sop_q [MASTERCOUNT];
   op_e                    sop_d [MASTERCOUNT];
   logic [ADDRBITSZ-1:0]   sad_q [MASTERCOUNT];
   logic [ADDRBITSZ-1:0]   sad_d [MASTERCOUNT];
   logic [ARCHBITSZ-1:0]   sdt_q [MASTERCOUNT];
   logic [ARCHBITSZ-1:0]   sdt_d [MASTERCOUNT];
   logic [SELW-1:0]        ssl_q [MASTERCOUNT];
   logic [SELW-1:0]        ssl_d [MASTERCOUNT];
   logic [ARCHBITSZ-1:0]   md_q  [MASTERCOUNT];
   logic [ARCHBITSZ-1:0]   md_d  [MASTERCOUNT];

   logic                   ov_q, ov_d, pend_q, pend_d;
   op_e                    oop_q, oop_d;
   logic [ADDRBITSZ-1:0]   oad_q, oad_d;
   logic [ARCHBITSZ-1:0]   odt_q, odt_d;
   logic [SELW-1:0]        osl_q, osl_d;
   logic [PW-1:0]          own_q, own_d, rr_q, rr_d, pidx_q, pidx_d;

   logic [MASTERCOUNT-1:0] rdy, elig;
   logic                   retire, capture, found_lo, found_hi;
   logic [PW-1:0]          g_lo, g_hi, gnt;

   always_comb begin
      rdy     = ~sv_q & ~rw_q & {MASTERCOUNT{~rst_i}};
      elig    = sv_q & ~si_q;
      retire  = ov_q & s_rdy_i & ~rst_i;
      capture = pend_q & s_rdy_i & ~rst_i;
   end

   // Lowest eligible index at or above rr_q wins; otherwise wrap to lowest eligible
   always_comb begin
      found_lo = 1'b0;
      found_hi = 1'b0;
      g_lo     = '0;
      g_hi     = '0;
      for (int unsigned i = 0; i < MASTERCOUNT; i++) begin
         if (elig[i] && !found_lo) begin
            found_lo = 1'b1;
            g_lo     = PW'(i);
         end
         if (elig[i] && (i >= 32'(rr_q)) && !found_hi) begin
            found_hi = 1'b1;
            g_hi     = PW'(i);
         end
      end
      gnt = found_hi ? g_hi : g_lo;
   end

   always_comb begin
      sv_d   = sv_q;
      si_d   = si_q;
      rw_d   = rw_q;
      sop_d  = sop_q;
      sad_d  = sad_q;
      sdt_d  = sdt_q;
      ssl_d  = ssl_q;
      md_d   = md_q;
      ov_d   = ov_q;
      oop_d  = oop_q;
      oad_d  = oad_q;
      odt_d  = odt_q;
      osl_d  = osl_q;
      own_d  = own_q;
      rr_d   = rr_q;
      pidx_d = pidx_q;
      pend_d = pend_q;

      if (capture) begin
         md_d[pidx_q] = s_data_i;
         rw_d[pidx_q] = 1'b0;
         pend_d       = 1'b0;
      end

      // A retiring read replaces the pending read captured on the same edge
      if (retire) begin
         sv_d[own_q] = 1'b0;
         si_d[own_q] = 1'b0;
         ov_d        = 1'b0;
         if (oop_q[1]) begin
            rw_d[own_q] = 1'b1;
            pend_d      = 1'b1;
            pidx_d      = own_q;
         end
      end

      if ((!ov_q || retire) && found_lo) begin
         ov_d      = 1'b1;
         oop_d     = sop_q[gnt];
         oad_d     = sad_q[gnt];
         odt_d     = sdt_q[gnt];
         osl_d     = ssl_q[gnt];
         own_d     = gnt;
         si_d[gnt] = 1'b1;
         rr_d      = (gnt == PW'(MASTERCOUNT-1)) ? '0 : gnt + 1'b1;
      end

      for (int unsigned i = 0; i < MASTERCOUNT; i++) begin
         if (rdy[i] && (m_op_i_flat[2*i +: 2] != 2'b00)) begin
            sv_d[i]  = 1'b1;
            si_d[i]  = 1'b0;
            sop_d[i] = op_e'(m_op_i_flat[2*i +: 2]);
            sad_d[i] = m_addr_i_flat[ADDRBITSZ*i +: ADDRBITSZ];
            sdt_d[i] = m_data_i_flat[ARCHBITSZ*i +: ARCHBITSZ];
            ssl_d[i] = m_sel_i_flat[SELW*i +: SELW];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sv_q   <= '0;
         si_q   <= '0;
         rw_q   <= '0;
         ov_q   <= 1'b0;
         oop_q  <= OP_NOOP;
         own_q  <= '0;
         rr_q   <= '0;
         pidx_q <= '0;
         pend_q <= 1'b0;
         for (int unsigned i = 0; i < MASTERCOUNT; i++) begin
            md_q[i] <= '0;
         end
      end else begin
         sv_q   <= sv_d;
         si_q   <= si_d;
         rw_q   <= rw_d;
         ov_q   <= ov_d;
         oop_q  <= oop_d;
         own_q  <= own_d;
         rr_q   <= rr_d;
         pidx_q <= pidx_d;
         pend_q <= pend_d;
         md_q   <= md_d;
      end
   end

   // Payload fields are qualified by the valid bits, so they need no reset
   always_ff @(posedge clk_i) begin
      sop_q <= sop_d;
      sad_q <= sad_d;
      sdt_q <= sdt_d;
      ssl_q <= ssl_d;
      oad_q <= oad_d;
      odt_q <= odt_d;
      osl_q <= osl_d;
   end

   always_comb begin
      m_data_o_flat = '0;
      for (int unsigned i = 0; i < MASTERCOUNT; i++) begin
         m_data_o_flat[ARCHBITSZ*i +: ARCHBITSZ] = md_q[i];
      end
      m_rdy_o_flat = rdy;
      s_op_o       = (ov_q && !rst_i) ? oop_q : OP_NOOP;
      s_addr_o     = oad_q;
      s_data_o     = odt_q;
      s_sel_o      = osl_q;
   end

endmodule

// File: tb/tb_pi1_rr_buf.sv
// Directed bench for pi1_rr_buf with three 16-bit masters.
module tb_pi1_rr_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  m_op;
   logic [44:0] m_addr;
   logic [47:0] m_data;
   logic [5:0]  m_sel;
   logic [47:0] m_dout;
   logic [2:0]  m_rdy;
   logic [1:0]  s_op;
   logic [14:0] s_addr;
   logic [15:0] s_dout;
   logic [1:0]  s_sel;
   logic [15:0] s_din;
   logic        s_rdy;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   pi1_rr_buf #(.MASTERCOUNT(3), .ARCHBITSZ(16)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .m_op_i_flat   (m_op),
      .m_addr_i_flat (m_addr),
      .m_data_i_flat (m_data),
      .m_sel_i_flat  (m_sel),
      .m_data_o_flat (m_dout),
      .m_rdy_o_flat  (m_rdy),
      .s_op_o        (s_op),
      .s_addr_o      (s_addr),
      .s_data_o      (s_dout),
      .s_sel_o       (s_sel),
      .s_data_i      (s_din),
      .s_rdy_i       (s_rdy)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input int m, input logic [1:0] op, input logic [14:0] a, input logic [15:0] d);
      m_op[2*m +: 2]    = op;
      m_addr[15*m +: 15] = a;
      m_data[16*m +: 16] = d;
      m_sel[2*m +: 2]   = 2'b11;
   endtask

   task automatic idle_all();
      m_op = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      checks++;
      if (m_rdy !== 3'b000 || s_op !== 2'b00) begin
         fails++;
         $display("FAIL reset_hold: m_rdy=%b s_op=%b expected 000/00", m_rdy, s_op);
      end
      step();
      rst = 1'b0;
      step();
      checks++;
      if (m_rdy !== 3'b111 || s_op !== 2'b00 || m_dout !== 48'h0) begin
         fails++;
         $display("FAIL reset_idle: m_rdy=%b s_op=%b m_dout=%h expected 111/00/0", m_rdy, s_op, m_dout);
      end
   endtask

   task automatic test_three_writes();
      s_rdy = 1'b1;
      issue(0, 2'b01, 15'h100, 16'hA000);
      issue(1, 2'b01, 15'h101, 16'hA001);
      issue(2, 2'b01, 15'h102, 16'hA002);
      step();
      idle_all();
      checks++;
      if (m_rdy !== 3'b000 || s_op !== 2'b00) begin
         fails++;
         $display("FAIL wr3_accept: m_rdy=%b s_op=%b expected 000/00", m_rdy, s_op);
      end
      step();
      checks++;
      if (s_op !== 2'b01 || s_addr !== 15'h100 || s_dout !== 16'hA000 || s_sel !== 2'b11) begin
         fails++;
         $display("FAIL wr3_g0: s_op=%b addr=%h data=%h sel=%b expected 01/100/a000/11", s_op, s_addr, s_dout, s_sel);
      end
      step();
      checks++;
      if (s_op !== 2'b01 || s_addr !== 15'h101 || s_dout !== 16'hA001 || m_rdy !== 3'b001) begin
         fails++;
         $display("FAIL wr3_g1: s_op=%b addr=%h data=%h m_rdy=%b expected 01/101/a001/001", s_op, s_addr, s_dout, m_rdy);
      end
      step();
      checks++;
      if (s_op !== 2'b01 || s_addr !== 15'h102 || m_rdy !== 3'b011) begin
         fails++;
         $display("FAIL wr3_g2: s_op=%b addr=%h m_rdy=%b expected 01/102/011", s_op, s_addr, m_rdy);
      end
      step();
      checks++;
      if (s_op !== 2'b00 || m_rdy !== 3'b111) begin
         fails++;
         $display("FAIL wr3_done: s_op=%b m_rdy=%b expected 00/111", s_op, m_rdy);
      end
   endtask

   task automatic test_rr_skip();
      // master 1 alone moves the pointer to 2
      s_rdy = 1'b1;
      issue(1, 2'b01, 15'h111, 16'h1111);
      step();
      idle_all();
      step();
      checks++;
      if (s_op !== 2'b01 || s_addr !== 15'h111) begin
         fails++;
         $display("FAIL rr_m1: s_op=%b addr=%h expected 01/111", s_op, s_addr);
      end
      step();
      s_rdy = 1'b0;
      issue(0, 2'b01, 15'h200, 16'h2000);
      issue(2, 2'b01, 15'h202, 16'h2002);
      step();
      idle_all();
      step();
      checks++;
      if (s_op !== 2'b01 || s_addr !== 15'h202) begin
         fails++;
         $display("FAIL rr_first: s_op=%b addr=%h expected 01/202", s_op, s_addr);
      end
      step();
      checks++;
      if (s_op !== 2'b01 || s_addr !== 15'h202 || m_rdy !== 3'b010) begin
         fails++;
         $display("FAIL rr_stall: s_op=%b addr=%h m_rdy=%b expected 01/202/010", s_op, s_addr, m_rdy);
      end
      s_rdy = 1'b1;
      step();
      checks++;
      if (s_op !== 2'b01 || s_addr !== 15'h200) begin
         fails++;
         $display("FAIL rr_second: s_op=%b addr=%h expected 01/200", s_op, s_addr);
      end
      step();
      checks++;
      if (s_op !== 2'b00 || m_rdy !== 3'b111) begin
         fails++;
         $display("FAIL rr_done: s_op=%b m_rdy=%b expected 00/111", s_op, m_rdy);
      end
   endtask

   task automatic test_read_wait();
      s_rdy = 1'b0;
      s_din = 16'h0000;
      issue(1, 2'b10, 15'h010, 16'h0000);
      step();
      idle_all();
      step();
      checks++;
      if (s_op !== 2'b10 || s_addr !== 15'h010 || m_rdy !== 3'b101) begin
         fails++;
         $display("FAIL rd_grant: s_op=%b addr=%h m_rdy=%b expected 10/010/101", s_op, s_addr, m_rdy);
      end
      for (int c = 0; c < 3; c++) step();
      checks++;
      if (s_op !== 2'b10 || m_rdy !== 3'b101) begin
         fails++;
         $display("FAIL rd_stall: s_op=%b m_rdy=%b expected 10/101", s_op, m_rdy);
      end
      s_rdy = 1'b1;
      s_din = 16'hBEEF;
      step();
      checks++;
      if (s_op !== 2'b00 || m_rdy !== 3'b101 || m_dout[31:16] !== 16'h0000) begin
         fails++;
         $display("FAIL rd_retired: s_op=%b m_rdy=%b m1_data=%h expected 00/101/0000", s_op, m_rdy, m_dout[31:16]);
      end
      step();
      checks++;
      if (m_dout[31:16] !== 16'hBEEF || m_rdy !== 3'b111) begin
         fails++;
         $display("FAIL rd_capture: m1_data=%h m_rdy=%b expected beef/111", m_dout[31:16], m_rdy);
      end
      s_rdy = 1'b0;
   endtask

   task automatic test_back_to_back();
      s_rdy = 1'b1;
      s_din = 16'hDEAD;
      issue(0, 2'b10, 15'h020, 16'h0000);
      step();
      idle_all();
      issue(2, 2'b01, 15'h030, 16'h5A5A);
      step();
      idle_all();
      checks++;
      if (s_op !== 2'b10 || s_addr !== 15'h020) begin
         fails++;
         $display("FAIL b2b_rd: s_op=%b addr=%h expected 10/020", s_op, s_addr);
      end
      step();
      checks++;
      if (s_op !== 2'b01 || s_addr !== 15'h030 || s_dout !== 16'h5A5A || m_rdy !== 3'b010) begin
         fails++;
         $display("FAIL b2b_wr: s_op=%b addr=%h data=%h m_rdy=%b expected 01/030/5a5a/010", s_op, s_addr, s_dout, m_rdy);
      end
      s_din = 16'h1234;
      step();
      checks++;
      if (s_op !== 2'b00 || m_dout[15:0] !== 16'h1234 || m_dout[31:16] !== 16'hBEEF || m_rdy !== 3'b111) begin
         fails++;
         $display("FAIL b2b_both: s_op=%b m0=%h m1=%h m_rdy=%b expected 00/1234/beef/111", s_op, m_dout[15:0], m_dout[31:16], m_rdy);
      end
   endtask

   task automatic test_reset_midop();
      s_rdy = 1'b0;
      issue(1, 2'b10, 15'h040, 16'h0000);
      step();
      idle_all();
      step();
      checks++;
      if (s_op !== 2'b10 || s_addr !== 15'h040) begin
         fails++;
         $display("FAIL rst_pre: s_op=%b addr=%h expected 10/040", s_op, s_addr);
      end
      rst   = 1'b1;
      s_rdy = 1'b1;
      s_din = 16'h5555;
      #1;
      checks++;
      if (s_op !== 2'b00 || m_rdy !== 3'b000) begin
         fails++;
         $display("FAIL rst_assert: s_op=%b m_rdy=%b expected 00/000", s_op, m_rdy);
      end
      step();
      checks++;
      if (s_op !== 2'b00 || m_rdy !== 3'b000 || m_dout !== 48'h0) begin
         fails++;
         $display("FAIL rst_during: s_op=%b m_rdy=%b m_dout=%h expected 00/000/0", s_op, m_rdy, m_dout);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (m_rdy !== 3'b111) begin
         fails++;
         $display("FAIL rst_release: m_rdy=%b expected 111", m_rdy);
      end
      step();
      checks++;
      if (s_op !== 2'b00 || m_rdy !== 3'b111 || m_dout !== 48'h0) begin
         fails++;
         $display("FAIL rst_nocapture: s_op=%b m_rdy=%b m_dout=%h expected 00/111/0", s_op, m_rdy, m_dout);
      end
   endtask

   initial begin
      rst    = 1'b1;
      m_op   = '0;
      m_addr = '0;
      m_data = '0;
      m_sel  = '0;
      s_din  = '0;
      s_rdy  = 1'b0;
      test_reset();
      test_three_writes();
      test_rr_skip();
      test_read_wait();
      test_back_to_back();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation exceeded 50000 time units");
      $fatal(1);
   end

endmodule
